// File: rtl/pipeline_pkg.sv
// Shared definitions for the 8-bit pipeline: data width, squash depth and
// the bit positions of the EX-to-MEM control bundle.
package pipeline_pkg;

    localparam int DATA_W           = 8;
    localparam int FLUSH_CYCLES_DEF = 3;

    localparam int CTRL_WR  = 0;
    localparam int CTRL_WM  = 1;
    localparam int CTRL_RM  = 2;
    localparam int CTRL_NEQ = 3;
    localparam int CTRL_J   = 4;
    localparam int CTRL_JC  = 5;
    localparam int CTRL_W   = 6;

    // Unconditional jump, or conditional jump whose zero flag disagrees with NEQ.
    function automatic logic branchTaken(input logic [CTRL_W-1:0] ctrl, input logic zero);
        return ctrl[CTRL_J] | (ctrl[CTRL_JC] & (zero ^ ctrl[CTRL_NEQ]));
    endfunction

endpackage

// File: rtl/data_mem.sv
// Byte-wide data memory: synchronous write, registered read that returns
// the old contents when reading and writing the same address.
module data_mem
    import pipeline_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clock,
    input  logic              writeEn,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] writeData,
    output logic [DATA_W-1:0] readData
);

    logic [DATA_W-1:0] memArray [2**ADDR_W];

    always_ff @(posedge clock) begin
        if (writeEn) begin
            memArray[addr] <= writeData;
        end
        readData <= memArray[addr];
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: data memory access, branch/jump resolution with a squash
// window for younger instructions, and the registers feeding WB.
module mem_stage
    import pipeline_pkg::*;
#(
    parameter int ADDR_W       = 8,
    parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
    parameter int CNT_W        = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] alu_in,
    input  logic              zero_in,
    input  logic [DATA_W-1:0] jump_target_in,
    input  logic [DATA_W-1:0] rs_in,
    input  logic [1:0]        rd_in,
    input  logic              wr_in,
    input  logic              wm_in,
    input  logic              rm_in,
    input  logic              neq_in,
    input  logic              j_in,
    input  logic              jc_in,
    output logic              pc_load,
    output logic [DATA_W-1:0] pc_target,
    output logic              flush,
    output logic [DATA_W-1:0] wb_data,
    output logic [1:0]        wb_rd,
    output logic              wb_wr
);

    logic [CNT_W-1:0]  squashCnt;
    logic [CNT_W-1:0]  nextCnt;
    logic              valid;
    logic              take;
    logic [CTRL_W-1:0] ctrlRaw;
    logic [CTRL_W-1:0] ctrl;
    logic              rmQ;
    logic [DATA_W-1:0] aluQ;
    logic [DATA_W-1:0] memReadData;

    assign valid = (squashCnt == '0);

    // Squashed instructions lose every control bit so they cannot store, load, write or branch.
    always_comb begin
        ctrlRaw           = '0;
        ctrlRaw[CTRL_WR]  = wr_in;
        ctrlRaw[CTRL_WM]  = wm_in;
        ctrlRaw[CTRL_RM]  = rm_in;
        ctrlRaw[CTRL_NEQ] = neq_in;
        ctrlRaw[CTRL_J]   = j_in;
        ctrlRaw[CTRL_JC]  = jc_in;
        ctrl              = valid ? ctrlRaw : '0;
    end

    assign take = branchTaken(ctrl, zero_in);

    always_comb begin
        nextCnt = squashCnt;
        if (take) begin
            nextCnt = CNT_W'(FLUSH_CYCLES);
        end else if (squashCnt != '0) begin
            nextCnt = squashCnt - CNT_W'(1);
        end
    end

    data_mem #(.ADDR_W(ADDR_W)) uDataMem (
        .clock     (clock),
        .writeEn   (ctrl[CTRL_WM]),
        .addr      (alu_in[ADDR_W-1:0]),
        .writeData (rs_in),
        .readData  (memReadData)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_load   <= 1'b0;
            pc_target <= '0;
            squashCnt <= '0;
            flush     <= 1'b0;
            aluQ      <= '0;
            rmQ       <= 1'b0;
            wb_rd     <= '0;
            wb_wr     <= 1'b0;
        end else begin
            pc_load <= take;
            if (take) begin
                pc_target <= jump_target_in;
            end
            squashCnt <= nextCnt;
            flush     <= (nextCnt != '0);
            aluQ      <= alu_in;
            rmQ       <= ctrl[CTRL_RM];
            wb_rd     <= rd_in;
            wb_wr     <= ctrl[CTRL_WR];
        end
    end

    // The memory read is already registered, so selecting it after the fact keeps loads at one cycle.
    assign wb_data = rmQ ? memReadData : aluQ;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_mem_stage;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] aluIn = '0;
    logic       zeroIn = 1'b0;
    logic [7:0] jumpTargetIn = '0;
    logic [7:0] rsIn = '0;
    logic [1:0] rdIn = '0;
    logic       wrIn = 1'b0, wmIn = 1'b0, rmIn = 1'b0, neqIn = 1'b0, jIn = 1'b0, jcIn = 1'b0;
    logic       pcLoad;
    logic [7:0] pcTarget;
    logic       flush;
    logic [7:0] wbData;
    logic [1:0] wbRd;
    logic       wbWr;

    int tests = 0;
    int fails = 0;

    logic [7:0] modelMem [256];
    bit         known [256];
    int         squashLeft = 0;
    logic       expPcLoad = 0, expFlush = 0, expWbWr = 0;
    logic [7:0] expPcTarget = '0, expWbData = '0;
    logic [1:0] expWbRd = '0;
    bit         expDataKnown = 1;

    mem_stage dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .alu_in         (aluIn),
        .zero_in        (zeroIn),
        .jump_target_in (jumpTargetIn),
        .rs_in          (rsIn),
        .rd_in          (rdIn),
        .wr_in          (wrIn),
        .wm_in          (wmIn),
        .rm_in          (rmIn),
        .neq_in         (neqIn),
        .j_in           (jIn),
        .jc_in          (jcIn),
        .pc_load        (pcLoad),
        .pc_target      (pcTarget),
        .flush          (flush),
        .wb_data        (wbData),
        .wb_rd          (wbRd),
        .wb_wr          (wbWr)
    );

    always #5 clock = ~clock;

    task automatic checkVal(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        squashLeft   = 0;
        expPcLoad    = 0;
        expPcTarget  = '0;
        expFlush     = 0;
        expWbData    = '0;
        expWbRd      = '0;
        expWbWr      = 0;
        expDataKnown = 1;
    endtask

    // One instruction's worth of architectural effect, straight from the stage's rules.
    task automatic modelStep();
        bit valid;
        bit take;
        valid = (squashLeft == 0);
        take  = valid && (jIn || (jcIn && (zeroIn != neqIn)));
        if (valid && rmIn) begin
            expDataKnown = known[aluIn];
            expWbData    = modelMem[aluIn];
        end else begin
            expDataKnown = 1;
            expWbData    = aluIn;
        end
        if (valid && wmIn) begin
            modelMem[aluIn] = rsIn;
            known[aluIn]    = 1;
        end
        expWbRd   = rdIn;
        expWbWr   = valid && wrIn;
        expPcLoad = take;
        if (take) expPcTarget = jumpTargetIn;
        if (take) squashLeft = 3;
        else if (squashLeft > 0) squashLeft--;
        expFlush = (squashLeft > 0);
    endtask

    task automatic checkOutput();
        checkVal("pc_load", 8'(pcLoad), 8'(expPcLoad));
        checkVal("pc_target", pcTarget, expPcTarget);
        checkVal("flush", 8'(flush), 8'(expFlush));
        checkVal("wb_rd", 8'(wbRd), 8'(expWbRd));
        checkVal("wb_wr", 8'(wbWr), 8'(expWbWr));
        if (expDataKnown) checkVal("wb_data", wbData, expWbData);
    endtask

    always @(posedge clock) begin
        if (reset_n) begin
            modelStep();
            #1;
            checkOutput();
        end
    end

    // Called at a falling edge; drives one instruction and returns at the next falling edge.
    task automatic applyStimulus(input logic [7:0] alu, input logic [7:0] rs, input logic [7:0] tgt,
                                 input logic [1:0] rd, input logic wr, input logic wm, input logic rm,
                                 input logic neq, input logic j, input logic jc, input logic zero);
        aluIn = alu; rsIn = rs; jumpTargetIn = tgt; rdIn = rd;
        wrIn = wr; wmIn = wm; rmIn = rm; neqIn = neq; jIn = j; jcIn = jc; zeroIn = zero;
        @(negedge clock);
    endtask

    task automatic nop();
        applyStimulus(8'h00, 8'h00, 8'h00, 2'd0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        repeat (2) @(negedge clock);
        checkVal("reset pc_load", 8'(pcLoad), 8'h00);
        checkVal("reset pc_target", pcTarget, 8'h00);
        checkVal("reset flush", 8'(flush), 8'h00);
        checkVal("reset wb_data", wbData, 8'h00);
        checkVal("reset wb_wr", 8'(wbWr), 8'h00);
        reset_n = 1'b1;

        applyStimulus(8'h10, 8'hA5, 8'h00, 2'd0, 0, 1, 0, 0, 0, 0, 0);
        applyStimulus(8'h10, 8'h00, 8'h00, 2'd2, 1, 0, 1, 0, 0, 0, 0);
        checkVal("load data", wbData, 8'hA5);
        checkVal("load rd", 8'(wbRd), 8'h02);
        checkVal("load wr", 8'(wbWr), 8'h01);

        applyStimulus(8'h00, 8'h00, 8'h3C, 2'd0, 0, 0, 0, 0, 0, 1, 1);
        checkVal("jc taken pc_load", 8'(pcLoad), 8'h01);
        checkVal("jc taken target", pcTarget, 8'h3C);
        checkVal("jc flush 1", 8'(flush), 8'h01);
        nop();
        checkVal("jc pulse end", 8'(pcLoad), 8'h00);
        checkVal("jc flush 2", 8'(flush), 8'h01);
        nop();
        checkVal("jc flush 3", 8'(flush), 8'h01);
        nop();
        checkVal("jc flush over", 8'(flush), 8'h00);

        applyStimulus(8'h00, 8'h00, 8'h55, 2'd0, 0, 0, 0, 0, 0, 1, 0);
        checkVal("jc not taken", 8'(pcLoad), 8'h00);
        checkVal("target held", pcTarget, 8'h3C);

        applyStimulus(8'h20, 8'h5A, 8'h00, 2'd0, 0, 1, 0, 0, 0, 0, 0);
        applyStimulus(8'h00, 8'h00, 8'h80, 2'd0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(8'h20, 8'hFF, 8'h00, 2'd1, 1, 1, 0, 0, 0, 0, 0);
            checkVal("squashed wb_wr", 8'(wbWr), 8'h00);
        end
        applyStimulus(8'h20, 8'h00, 8'h00, 2'd1, 1, 0, 1, 0, 0, 0, 0);
        checkVal("post-squash wb_wr", 8'(wbWr), 8'h01);
        checkVal("squashed store blocked", wbData, 8'h5A);

        applyStimulus(8'h00, 8'h00, 8'h11, 2'd0, 0, 0, 0, 0, 1, 0, 0);
        checkVal("b2b first target", pcTarget, 8'h11);
        applyStimulus(8'h00, 8'h00, 8'h22, 2'd0, 0, 0, 0, 0, 1, 0, 0);
        checkVal("b2b single pulse", 8'(pcLoad), 8'h00);
        checkVal("b2b target kept", pcTarget, 8'h11);
        repeat (3) nop();

        applyStimulus(8'h05, 8'h11, 8'h00, 2'd0, 0, 1, 0, 0, 0, 0, 0);
        applyStimulus(8'h05, 8'h22, 8'h00, 2'd3, 1, 1, 1, 0, 0, 0, 0);
        checkVal("rbw old value", wbData, 8'h11);
        applyStimulus(8'h05, 8'h00, 8'h00, 2'd3, 1, 0, 1, 0, 0, 0, 0);
        checkVal("rbw new value", wbData, 8'h22);

        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15)),
                          8'($urandom), 8'($urandom), 2'($urandom),
                          1'($urandom), ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                          1'($urandom), ($urandom_range(0, 15) == 0), ($urandom_range(0, 5) == 0),
                          1'($urandom));
        end

        repeat (4) nop();
        applyStimulus(8'h07, 8'h00, 8'h99, 2'd3, 1, 0, 0, 0, 1, 0, 0);
        checkVal("pre-reset pc_load", 8'(pcLoad), 8'h01);
        checkVal("pre-reset flush", 8'(flush), 8'h01);
        reset_n = 1'b0;
        #1;
        modelReset();
        checkVal("async flush", 8'(flush), 8'h00);
        checkVal("async pc_load", 8'(pcLoad), 8'h00);
        checkVal("async wb_wr", 8'(wbWr), 8'h00);
        checkVal("async wb_data", wbData, 8'h00);
        @(negedge clock);
        reset_n = 1'b1;
        applyStimulus(8'h40, 8'hC3, 8'h00, 2'd0, 0, 1, 0, 0, 0, 0, 0);
        applyStimulus(8'h40, 8'h00, 8'h00, 2'd1, 1, 0, 1, 0, 0, 0, 0);
        checkVal("store at reset release", wbData, 8'hC3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
